// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed controller for a 31-tap symmetric low-pass FIR.
// One pre-add/multiply/accumulate step per clock over the 16 coefficient pairs, valid/ready output.
module fir_mac_sequencer #(
    parameter int DATA_W = 10,
    parameter int TAPS   = 31,
    parameter int SHIFT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              sample_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] filtered,
    output logic              busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int PAIRS  = (TAPS + 1) / 2;
    localparam int KW     = $clog2(PAIRS);
    localparam int PW     = $clog2(TAPS);
    localparam int COEF_W = 7;
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + 8;
    localparam int ACC_W  = DATA_W + 11;

    localparam logic [COEF_W-1:0] COEF [PAIRS] = '{
        7'd3,  7'd4,  7'd6,  7'd8,  7'd12, 7'd17, 7'd23, 7'd29,
        7'd36, 7'd43, 7'd50, 7'd56, 7'd61, 7'd65, 7'd67, 7'd68
    };

    typedef enum logic [1:0] {IDLE, MAC, OUT, HOLD} state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  hist_reg [TAPS];
    logic [PW-1:0]      wptr_reg;
    logic [PW-1:0]      newest_reg;
    logic [KW-1:0]      k_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [DATA_W-1:0]  filtered_reg;
    logic               out_valid_reg;
    logic               sample_ready_reg;
    logic               busy_reg;
    logic               overrun_reg;

    logic [PW:0]        idx_a_raw, idx_b_raw;
    logic [PW-1:0]      idx_a, idx_b;
    logic [PRE_W-1:0]   pre_sum;
    logic [PROD_W-1:0]  product;
    logic [ACC_W-1:0]   acc_shifted;
    logic [DATA_W-1:0]  sat_value;
    logic               accept;

    assign accept = sample_valid && sample_ready_reg;

    // Older tap walks backwards from newest, its mirror walks forwards from the oldest entry.
    always_comb begin
        idx_a_raw = {1'b0, newest_reg} + (PW+1)'(TAPS) - (PW+1)'(k_reg);
        idx_b_raw = {1'b0, newest_reg} + (PW+1)'(1) + (PW+1)'(k_reg);
        idx_a = (idx_a_raw >= (PW+1)'(TAPS)) ? PW'(idx_a_raw - (PW+1)'(TAPS)) : PW'(idx_a_raw);
        idx_b = (idx_b_raw >= (PW+1)'(TAPS)) ? PW'(idx_b_raw - (PW+1)'(TAPS)) : PW'(idx_b_raw);
        if (k_reg == KW'(PAIRS - 1))
            pre_sum = {1'b0, hist_reg[idx_a]};
        else
            pre_sum = {1'b0, hist_reg[idx_a]} + {1'b0, hist_reg[idx_b]};
        product = PROD_W'(COEF[k_reg]) * PROD_W'(pre_sum);
    end

    always_comb begin
        acc_shifted = acc_reg >> SHIFT;
        if (acc_shifted > ACC_W'({DATA_W{1'b1}}))
            sat_value = '1;
        else
            sat_value = acc_shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) hist_reg[i] <= '0;
        end else if (accept) begin
            hist_reg[wptr_reg] <= sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            wptr_reg         <= '0;
            newest_reg       <= '0;
            k_reg            <= '0;
            acc_reg          <= '0;
            filtered_reg     <= '0;
            out_valid_reg    <= 1'b0;
            sample_ready_reg <= 1'b1;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sample_valid) begin
                        newest_reg       <= wptr_reg;
                        wptr_reg         <= (wptr_reg == PW'(TAPS - 1)) ? '0 : wptr_reg + PW'(1);
                        acc_reg          <= '0;
                        k_reg            <= '0;
                        sample_ready_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                        state_reg        <= MAC;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + ACC_W'(product);
                    k_reg   <= k_reg + KW'(1);
                    if (k_reg == KW'(PAIRS - 1))
                        state_reg <= OUT;
                end
                OUT: begin
                    filtered_reg  <= sat_value;
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg    <= 1'b0;
                        sample_ready_reg <= 1'b1;
                        busy_reg         <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle drop so software never loses its acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overrun_reg <= 1'b0;
        else if (overrun_clr)
            overrun_reg <= 1'b0;
        else if (sample_valid && !sample_ready_reg)
            overrun_reg <= 1'b1;
    end

    assign sample_ready = sample_ready_reg;
    assign out_valid    = out_valid_reg;
    assign filtered     = filtered_reg;
    assign busy         = busy_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: direct-convolution model with a per-cycle output compare,
// plus hand-computed literals for impulse, DC, saturation and reset-recovery cases.
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [9:0] sample;
    logic       sample_ready;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] filtered;
    logic       busy;
    logic       overrun;
    logic       overrun_clr;

    fir_mac_sequencer dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .sample_ready(sample_ready), .out_valid(out_valid), .out_ready(out_ready),
        .filtered(filtered), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int xs[$];
    int exp_q[$];
    int acc_cyc_q[$];
    int last_out = -1;
    int n_out = 0;
    bit prev_ov = 1'b0;
    int coefs[16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
    int imp[31] = '{2, 3, 5, 7, 11, 16, 22, 28, 35, 41, 48, 54, 59, 63, 65, 66,
                    65, 63, 59, 54, 48, 41, 35, 28, 22, 16, 11, 7, 5, 3, 2};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // y[n] = floor(sum_j h[j]*x[n-j] / 1024), h symmetric, zero history before the first sample
    function automatic int model_y();
        int n = xs.size() - 1;
        int y = 0;
        for (int j = 0; j < 31; j++)
            if (n - j >= 0) y += coefs[(j <= 15) ? j : 30 - j] * xs[n - j];
        y = y >> 10;
        if (y > 1023) y = 1023;
        return y;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prev_ov) begin
                if (acc_cyc_q.size() > 0) check("latency_edges", cyc - acc_cyc_q.pop_front(), 17);
                else check("out_valid_unexpected", int'(out_valid), 0);
            end
            if (out_valid && exp_q.size() > 0) begin
                check("filtered", int'(filtered), exp_q[0]);
                if (out_ready) begin
                    last_out = int'(filtered);
                    n_out++;
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic clear_model();
        xs.delete();
        exp_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!sample_ready && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!sample_ready) check("ready_timeout", int'(sample_ready), 1);
    endtask

    task automatic send(input int x);
        wait_ready();
        if (sample_ready) begin
            sample_valid = 1'b1;
            sample       = 10'(x);
            @(posedge clk);
            #1 sample_valid = 1'b0;
            xs.push_back(x);
            exp_q.push_back(model_y());
            acc_cyc_q.push_back(cyc);
        end
    endtask

    task automatic dc_case(input int v, input int want);
        do_reset();
        for (int i = 0; i < 33; i++) send(v);
        wait_ready();
        check("dc_model", model_y(), want);
        check("dc_out", last_out, want);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample = '0; out_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_sample_ready", int'(sample_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_filtered", int'(filtered), 0);
        check("reset_overrun", int'(overrun), 0);

        // impulse response: every output pinned to its literal value
        for (int i = 0; i < 31; i++) begin
            send((i == 0) ? 1000 : 0);
            check("impulse_model", exp_q[$], imp[i]);
            wait_ready();
            check("impulse_out", last_out, imp[i]);
        end

        dc_case(512, 514);
        dc_case(1023, 1023);
        dc_case(1000, 1003);

        // backpressure with dropped samples, then a known-sequence resume
        do_reset();
        for (int i = 0; i < 31; i++) send((i * 37) % 1024);
        wait_ready();
        out_ready = 1'b0;
        send(777);
        for (int c = 0; c < 50; c++) begin
            if (c % 10 == 0) begin
                sample_valid = 1'b1;
                sample       = 10'd5;
            end
            @(posedge clk);
            #1 sample_valid = 1'b0;
            if (c == 0) check("busy_during_mac", int'(busy), 1);
            if (c == 10) check("overrun_set", int'(overrun), 1);
        end
        check("hold_out_valid", int'(out_valid), 1);
        check("hold_sample_ready", int'(sample_ready), 0);
        check("hold_overrun", int'(overrun), 1);
        check("hold_pending", exp_q.size(), 1);
        overrun_clr  = 1'b1;
        sample_valid = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        sample_valid = 1'b0;
        check("overrun_clr_priority", int'(overrun), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(900 - i * 111);
        wait_ready();
        check("resume_drained", exp_q.size(), 0);

        // pointer wrap across two full passes of the history
        do_reset();
        n_out = 0;
        for (int i = 0; i < 70; i++) send(i);
        wait_ready();
        check("wrap_output_count", n_out, 70);

        // asynchronous reset in the middle of accumulation
        do_reset();
        send(500);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        clear_model();
        #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_sample_ready", int'(sample_ready), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        send(800);
        check("midreset_model", exp_q[$], 2);
        wait_ready();
        check("midreset_first_out", last_out, 2);

        repeat (5) @(posedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
